// File: rtl/mmio_io_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mmio_io_responder                                               |
// | Purpose  : CPU I/O-space slave: LED/7-seg registers, debounced switches,   |
// |            down-counting timer with sticky, clear-on-read expiry flag.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mmio_io_responder #(
    parameter int SW_WIDTH  = 24,
    parameter int LED_WIDTH = 24,
    parameter int DB_CYCLES = 100000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_read,
    input  logic                 io_write,
    input  logic [9:0]           addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 bad_addr,
    input  logic [SW_WIDTH-1:0]  switch_i,
    output logic [LED_WIDTH-1:0] led_o,
    output logic [31:0]          seg_value_o,
    output logic                 timer_irq_o
);

    localparam logic [9:0] c_ADDR_LED     = 10'h060;
    localparam logic [9:0] c_ADDR_SW      = 10'h070;
    localparam logic [9:0] c_ADDR_SEG     = 10'h080;
    localparam logic [9:0] c_ADDR_TCTRL   = 10'h090;
    localparam logic [9:0] c_ADDR_TLOAD   = 10'h094;
    localparam logic [9:0] c_ADDR_TCOUNT  = 10'h098;
    localparam logic [9:0] c_ADDR_TSTATUS = 10'h09C;

    localparam int              c_DB_W    = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DB_CYCLES - 1);

    logic [7:0]           w_word;
    logic                 w_sel_led, w_sel_sw, w_sel_seg, w_sel_tctrl;
    logic                 w_sel_tload, w_sel_tcount, w_sel_tstatus;
    logic                 w_mapped, w_read_only;
    logic                 w_wr_tload, w_wr_tctrl, w_rd_tstatus, w_expire;
    logic                 w_unused_addr;

    logic [LED_WIDTH-1:0] r_led;
    logic [31:0]          r_seg;
    logic                 r_en, r_autoreload, r_expired, r_bad_addr;
    logic [31:0]          r_tload, r_tcount;
    logic [SW_WIDTH-1:0]  r_sw_sync1, r_sw_sync2, r_sw_stable;
    logic [c_DB_W-1:0]    r_sw_cnt;

    assign w_word        = addr[9:2];
    assign w_unused_addr = ^addr[1:0];

    assign w_sel_led     = (w_word == c_ADDR_LED[9:2]);
    assign w_sel_sw      = (w_word == c_ADDR_SW[9:2]);
    assign w_sel_seg     = (w_word == c_ADDR_SEG[9:2]);
    assign w_sel_tctrl   = (w_word == c_ADDR_TCTRL[9:2]);
    assign w_sel_tload   = (w_word == c_ADDR_TLOAD[9:2]);
    assign w_sel_tcount  = (w_word == c_ADDR_TCOUNT[9:2]);
    assign w_sel_tstatus = (w_word == c_ADDR_TSTATUS[9:2]);

    assign w_read_only = w_sel_sw | w_sel_tcount | w_sel_tstatus;
    assign w_mapped    = w_read_only | w_sel_led | w_sel_seg | w_sel_tctrl | w_sel_tload;

    assign w_wr_tload   = io_write & w_sel_tload;
    assign w_wr_tctrl   = io_write & w_sel_tctrl;
    assign w_rd_tstatus = io_read & w_sel_tstatus;
    // Reload writes take priority over the expiry rule, so they also mask expiry.
    assign w_expire     = ~w_wr_tload & r_en & (r_tcount == 32'd0);

    always_comb begin
        rdata = 32'd0;
        if (io_read) begin
            if (w_sel_led)     rdata[LED_WIDTH-1:0] = r_led;
            if (w_sel_sw)      rdata[SW_WIDTH-1:0]  = r_sw_stable;
            if (w_sel_seg)     rdata                = r_seg;
            if (w_sel_tctrl)   rdata[1:0]           = {r_autoreload, r_en};
            if (w_sel_tload)   rdata                = r_tload;
            if (w_sel_tcount)  rdata                = r_tcount;
            if (w_sel_tstatus) rdata[0]             = r_expired;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_led      <= '0;
            r_seg      <= '0;
            r_bad_addr <= 1'b0;
        end else begin
            if (io_write && w_sel_led) r_led <= wdata[LED_WIDTH-1:0];
            if (io_write && w_sel_seg) r_seg <= wdata;
            r_bad_addr <= ((io_read | io_write) & ~w_mapped) | (io_write & w_read_only);
        end
    end

    // Whole-vector debounce: any mid-count change just retargets the comparison.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sw_sync1  <= '0;
            r_sw_sync2  <= '0;
            r_sw_stable <= '0;
            r_sw_cnt    <= '0;
        end else begin
            r_sw_sync1 <= switch_i;
            r_sw_sync2 <= r_sw_sync1;
            if (r_sw_sync2 != r_sw_stable) begin
                if (r_sw_cnt == c_DB_LAST) begin
                    r_sw_stable <= r_sw_sync2;
                    r_sw_cnt    <= '0;
                end else begin
                    r_sw_cnt <= r_sw_cnt + c_DB_W'(1);
                end
            end else begin
                r_sw_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_en         <= 1'b0;
            r_autoreload <= 1'b0;
            r_tload      <= 32'd0;
            r_tcount     <= 32'd0;
            r_expired    <= 1'b0;
        end else begin
            if (w_wr_tload) begin
                r_tload  <= wdata;
                r_tcount <= wdata;
            end else if (r_en && (r_tcount != 32'd0)) begin
                r_tcount <= r_tcount - 32'd1;
            end else if (r_en) begin
                if (r_autoreload) r_tcount <= r_tload;
                else              r_en     <= 1'b0;
            end
            // A control write overrides the one-shot auto-disable above.
            if (w_wr_tctrl) begin
                r_en         <= wdata[0];
                r_autoreload <= wdata[1];
            end
            if (w_expire)          r_expired <= 1'b1;
            else if (w_rd_tstatus) r_expired <= 1'b0;
        end
    end

    assign led_o       = r_led;
    assign seg_value_o = r_seg;
    assign bad_addr    = r_bad_addr;
    assign timer_irq_o = r_expired;

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mmio_io_responder                                            |
// | Purpose  : Directed self-checking bench for mmio_io_responder.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mmio_io_responder;

    localparam int SW_WIDTH  = 24;
    localparam int LED_WIDTH = 24;
    localparam logic [9:0] A_LED = 10'h060, A_SW = 10'h070, A_SEG = 10'h080;
    localparam logic [9:0] A_TCTRL = 10'h090, A_TLOAD = 10'h094;
    localparam logic [9:0] A_TCOUNT = 10'h098, A_TSTATUS = 10'h09C, A_BAD = 10'h0A0;

    logic                 clock, reset, io_read, io_write, bad_addr, timer_irq_o;
    logic [9:0]           addr;
    logic [31:0]          wdata, rdata, seg_value_o;
    logic [SW_WIDTH-1:0]  switch_i;
    logic [LED_WIDTH-1:0] led_o;

    int n_vec = 0;
    int n_err = 0;

    mmio_io_responder #(.SW_WIDTH(SW_WIDTH), .LED_WIDTH(LED_WIDTH), .DB_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .io_read(io_read), .io_write(io_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .bad_addr(bad_addr),
        .switch_i(switch_i), .led_o(led_o), .seg_value_o(seg_value_o),
        .timer_irq_o(timer_irq_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every access task starts in the low phase and consumes exactly one rising edge.
    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        io_write = 1'b1; addr = a; wdata = d;
        @(negedge clock);
        io_write = 1'b0; wdata = 32'd0;
    endtask

    task automatic rd(input logic [9:0] a, output logic [31:0] d);
        io_read = 1'b1; addr = a;
        #1 d = rdata;
        @(negedge clock);
        io_read = 1'b0;
    endtask

    task automatic peek(input logic [9:0] a, output logic [31:0] d);
        io_read = 1'b1; addr = a;
        #1 d = rdata;
        io_read = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        repeat (2) @(posedge clock);
        #1;
        n_vec++; if (led_o !== 24'h0) begin n_err++; $display("FAIL reset_led: got %h want 0", led_o); end
        n_vec++; if (seg_value_o !== 32'h0) begin n_err++; $display("FAIL reset_seg: got %h want 0", seg_value_o); end
        n_vec++; if ({bad_addr, timer_irq_o} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {bad_addr, timer_irq_o}); end
        @(negedge clock);
        reset = 1'b0;
        peek(A_TCOUNT, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_tcount: got %h want 0", d); end
    endtask

    task automatic test_led_seg;
        logic [31:0] d;
        wr(A_LED, 32'h00ABCDEF);
        n_vec++; if (led_o !== 24'hABCDEF) begin n_err++; $display("FAIL led_write: got %h want abcdef", led_o); end
        wr(A_SEG, 32'h12345678);
        n_vec++; if (seg_value_o !== 32'h12345678) begin n_err++; $display("FAIL seg_write: got %h want 12345678", seg_value_o); end
        n_vec++; if (bad_addr !== 1'b0) begin n_err++; $display("FAIL seg_bad_addr: got %b want 0", bad_addr); end
        rd(A_LED, d);
        n_vec++; if (d !== 32'h00ABCDEF) begin n_err++; $display("FAIL led_read: got %h want 00abcdef", d); end
        rd(A_SEG, d);
        n_vec++; if (d !== 32'h12345678) begin n_err++; $display("FAIL seg_read: got %h want 12345678", d); end
        addr = A_LED;
        #1;
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rdata_idle: got %h want 0", rdata); end
        // Both strobes: old value is read, write still commits with high bits dropped.
        io_read = 1'b1; io_write = 1'b1; wdata = 32'hFF111111;
        #1;
        n_vec++; if (rdata !== 32'h00ABCDEF) begin n_err++; $display("FAIL both_rdata: got %h want 00abcdef", rdata); end
        @(negedge clock);
        io_read = 1'b0; io_write = 1'b0;
        n_vec++; if (led_o !== 24'h111111) begin n_err++; $display("FAIL both_write: got %h want 111111", led_o); end
        peek(A_LED, d);
        n_vec++; if (d !== 32'h00111111) begin n_err++; $display("FAIL led_trunc: got %h want 00111111", d); end
    endtask

    task automatic test_debounce;
        logic [31:0] d;
        switch_i = 24'h000005;
        repeat (5) @(negedge clock);
        peek(A_SW, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL db_early: got %h want 0", d); end
        @(negedge clock);
        peek(A_SW, d);
        n_vec++; if (d !== 32'h5) begin n_err++; $display("FAIL db_accept: got %h want 5", d); end
        switch_i = 24'h000007;
        repeat (2) @(negedge clock);
        switch_i = 24'h000005;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            peek(A_SW, d);
            n_vec++; if (d !== 32'h5) begin n_err++; $display("FAIL db_glitch[%0d]: got %h want 5", i, d); end
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] d;
        logic [31:0] exp_cnt [4];
        exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd0};
        wr(A_TLOAD, 32'd3);
        wr(A_TCTRL, 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd(A_TCOUNT, d);
            n_vec++; if (d !== exp_cnt[i]) begin n_err++; $display("FAIL tcount[%0d]: got %0d want %0d", i, d, exp_cnt[i]); end
        end
        n_vec++; if (timer_irq_o !== 1'b1) begin n_err++; $display("FAIL oneshot_irq: got %b want 1", timer_irq_o); end
        rd(A_TCTRL, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL oneshot_en: got %h want 0", d); end
        rd(A_TCOUNT, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL oneshot_hold: got %h want 0", d); end
        rd(A_TSTATUS, d);
        n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL status_first: got %h want 1", d); end
        rd(A_TSTATUS, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL status_cleared: got %h want 0", d); end
        n_vec++; if (timer_irq_o !== 1'b0) begin n_err++; $display("FAIL irq_cleared: got %b want 0", timer_irq_o); end
    endtask

    task automatic test_autoreload;
        logic [31:0] d;
        logic [9:0]  exp_st;
        // Reads every cycle; the read at each expiry edge must not clear the flag.
        exp_st = 10'b1001001000;
        wr(A_TLOAD, 32'd2);
        wr(A_TCTRL, 32'd3);
        for (int i = 0; i < 10; i++) begin
            rd(A_TSTATUS, d);
            n_vec++; if (d !== {31'd0, exp_st[i]}) begin n_err++; $display("FAIL autoreload[%0d]: got %h want %0d", i, d, exp_st[i]); end
        end
        wr(A_TCTRL, 32'd0);
    endtask

    task automatic test_bad_access;
        logic [31:0] d;
        rd(A_BAD, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL bad_rdata: got %h want 0", d); end
        n_vec++; if (bad_addr !== 1'b1) begin n_err++; $display("FAIL bad_read_pulse: got %b want 1", bad_addr); end
        @(negedge clock);
        n_vec++; if (bad_addr !== 1'b0) begin n_err++; $display("FAIL bad_pulse_end: got %b want 0", bad_addr); end
        wr(A_SW, 32'h00FFFFFF);
        n_vec++; if (bad_addr !== 1'b1) begin n_err++; $display("FAIL ro_write_pulse: got %b want 1", bad_addr); end
        peek(A_SW, d);
        n_vec++; if (d !== 32'h5) begin n_err++; $display("FAIL ro_sw_kept: got %h want 5", d); end
        rd(A_TSTATUS, d);
        n_vec++; if (bad_addr !== 1'b0) begin n_err++; $display("FAIL ro_read_ok: got %b want 0", bad_addr); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        wr(A_TLOAD, 32'd9);
        wr(A_TCTRL, 32'd1);
        switch_i = 24'h00000A;
        repeat (3) @(negedge clock);
        rd(A_BAD, d);
        peek(A_TCOUNT, d);
        n_vec++; if (d !== 32'd5) begin n_err++; $display("FAIL pre_reset_tcount: got %0d want 5", d); end
        n_vec++; if (bad_addr !== 1'b1) begin n_err++; $display("FAIL pre_reset_bad: got %b want 1", bad_addr); end
        io_read = 1'b1; addr = A_TCOUNT;
        #2 reset = 1'b1;
        #1;
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL async_tcount: got %h want 0", rdata); end
        n_vec++; if ({led_o, seg_value_o} !== 56'h0) begin n_err++; $display("FAIL async_outputs: got %h want 0", {led_o, seg_value_o}); end
        n_vec++; if ({bad_addr, timer_irq_o} !== 2'b00) begin n_err++; $display("FAIL async_flags: got %b want 00", {bad_addr, timer_irq_o}); end
        addr = A_SW;
        #1;
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL async_sw: got %h want 0", rdata); end
        io_read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        peek(A_TCOUNT, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL post_reset_tcount: got %h want 0", d); end
    endtask

    initial begin
        reset = 1'b1; io_read = 1'b0; io_write = 1'b0;
        addr = 10'h0; wdata = 32'h0; switch_i = '0;
        test_reset;
        test_led_seg;
        test_debounce;
        test_oneshot;
        test_autoreload;
        test_bad_access;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
